// File: rtl/ejtag_pracc_hs_ctrl_pkg.sv
// Shared definitions for the EJTAG PrAcc handshake controller: FSM encoding
// and the default timeout configuration.
package ejtag_pracc_hs_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int TO_WIDTH_DEF = 8;
  localparam int TO_LIMIT_DEF = 200;

endpackage

// File: rtl/ejtag_pracc_hs_ctrl_sync.sv
// SYNC_STAGES-deep level synchroniser (ejtag_hs_sync) with a synchronous,
// active-high clear. Legal depths are 2 and 3.
module ejtag_hs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge CLK) begin
    if (RESET) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  assign q = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ejtag_pracc_hs_ctrl.sv
// Core-side EJTAG PrAcc 4-phase handshake controller. The bounded wait for
// DBG_ACK (counter + sticky TIMEOUT_ERR) is built only with EJTAG_PRACC_TIMEOUT_EN.
module ejtag_pracc_hs_ctrl
  import ejtag_pracc_hs_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TO_WIDTH    = TO_WIDTH_DEF,
  parameter int TO_LIMIT    = TO_LIMIT_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PRACC_REQ_IN,
  input  logic PRACC_WR_IN,
  input  logic DBG_ACK,
  input  logic ERR_CLR,
  output logic DBG_REQ,
  output logic DBG_WR,
  output logic PRACC_ACK_OUT,
  output logic BUSY,
  output logic TIMEOUT_ERR
);

  logic   req_s, wr_s;
  state_t state_q, state_d;
  logic   dbg_req_d, dbg_wr_d, ack_d;
  logic   timeout_hit;

  ejtag_hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (PRACC_REQ_IN),
    .q     (req_s)
  );

  ejtag_hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (PRACC_WR_IN),
    .q     (wr_s)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      DBG_REQ       <= 1'b0;
      DBG_WR        <= 1'b0;
      PRACC_ACK_OUT <= 1'b0;
    end else begin
      state_q       <= state_d;
      DBG_REQ       <= dbg_req_d;
      DBG_WR        <= dbg_wr_d;
      PRACC_ACK_OUT <= ack_d;
    end
  end

  // DBG_ACK and timeout share the REQ->ACK exit; only the error flag tells them apart.
  always_comb begin
    state_d   = state_q;
    dbg_req_d = DBG_REQ;
    dbg_wr_d  = DBG_WR;
    ack_d     = PRACC_ACK_OUT;
    unique case (state_q)
      ST_IDLE: if (req_s) begin
        state_d   = ST_REQ;
        dbg_req_d = 1'b1;
        dbg_wr_d  = wr_s;
      end
      ST_REQ: if (DBG_ACK || timeout_hit) begin
        state_d   = ST_ACK;
        dbg_req_d = 1'b0;
        dbg_wr_d  = 1'b0;
        ack_d     = 1'b1;
      end
      ST_ACK: if (!req_s) begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        dbg_req_d = 1'b0;
        dbg_wr_d  = 1'b0;
        ack_d     = 1'b0;
      end
    endcase
  end

  assign BUSY = (state_q != ST_IDLE);

`ifdef EJTAG_PRACC_TIMEOUT_EN
  logic [TO_WIDTH-1:0] cnt_q;
  logic                to_fire;

  assign timeout_hit = (state_q == ST_REQ) && (cnt_q == TO_WIDTH'(TO_LIMIT - 1));
  assign to_fire     = timeout_hit && !DBG_ACK;

  // Held at zero in IDLE so every REQ starts counting from 0; saturates at all-ones.
  always_ff @(posedge CLK) begin
    if (RESET)                                cnt_q <= '0;
    else if (state_q == ST_IDLE)              cnt_q <= '0;
    else if (state_q == ST_REQ && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET)        TIMEOUT_ERR <= 1'b0;
    else if (to_fire) TIMEOUT_ERR <= 1'b1;
    else if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
  end
`else
  localparam bit TO_CFG_OK = (TO_LIMIT >= 1) && (TO_LIMIT < (1 << TO_WIDTH));
  logic unused_to;

  assign unused_to   = TO_CFG_OK ^ ERR_CLR;
  assign timeout_hit = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ejtag_pracc_hs_ctrl.sv
// Directed bench for ejtag_pracc_hs_ctrl; follows EJTAG_PRACC_TIMEOUT_EN for the timeout cases.
module tb_ejtag_pracc_hs_ctrl;

  localparam int SYNC = 2;
  localparam int TOL  = 4;
`ifdef EJTAG_PRACC_TIMEOUT_EN
  localparam int ACK_DLY = 2;
`else
  localparam int ACK_DLY = 5;
`endif

  // Output vector order: {DBG_REQ, DBG_WR, PRACC_ACK_OUT, BUSY, TIMEOUT_ERR}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_RD    = 5'b10010;
  localparam logic [4:0] O_WR    = 5'b11010;
  localparam logic [4:0] O_ACK   = 5'b00110;
  localparam logic [4:0] O_TOACK = 5'b00111;
  localparam logic [4:0] O_ERR   = 5'b00001;

  logic CLK = 1'b0;
  logic RESET, req_in, wr_in, dbg_ack, err_clr;
  logic dbg_req, dbg_wr, ack_out, busy, to_err;
  logic [4:0] outs;
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;
  assign outs = {dbg_req, dbg_wr, ack_out, busy, to_err};

  ejtag_pracc_hs_ctrl #(.SYNC_STAGES(SYNC), .TO_WIDTH(8), .TO_LIMIT(TOL)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PRACC_REQ_IN  (req_in),
    .PRACC_WR_IN   (wr_in),
    .DBG_ACK       (dbg_ack),
    .ERR_CLR       (err_clr),
    .DBG_REQ       (dbg_req),
    .DBG_WR        (dbg_wr),
    .PRACC_ACK_OUT (ack_out),
    .BUSY          (busy),
    .TIMEOUT_ERR   (to_err)
  );

  task automatic chk(string tag, logic [4:0] got, logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ack_pulse();
    dbg_ack = 1'b1;
    tick();
    dbg_ack = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; req_in = 1'b0; wr_in = 1'b0; dbg_ack = 1'b0; err_clr = 1'b0;
    tick(2);
    chk("reset", outs, O_IDLE);
    RESET = 1'b0;
    tick();
    chk("idle", outs, O_IDLE);

    // Read access
    req_in = 1'b1;
    tick();        chk("rd_k",   outs, O_IDLE);
    tick();        chk("rd_k1",  outs, O_IDLE);
    tick();        chk("rd_k2",  outs, O_RD);
    for (int i = 1; i < ACK_DLY; i++) begin
      tick();      chk("rd_wait", outs, O_RD);
    end
    ack_pulse();   chk("rd_ack", outs, O_ACK);
    req_in = 1'b0;
    tick();        chk("rd_n",   outs, O_ACK);
    tick();        chk("rd_n1",  outs, O_ACK);
    tick();        chk("rd_n2",  outs, O_IDLE);

    // Write access, direction set 3 cycles ahead of REQ
    wr_in = 1'b1;
    tick(3);
    req_in = 1'b1;
    tick(SYNC);    chk("wr_pre", outs, O_IDLE);
    tick();        chk("wr_req", outs, O_WR);
    for (int i = 1; i < ACK_DLY; i++) begin
      tick();      chk("wr_hold", outs, O_WR);
    end
    ack_pulse();   chk("wr_ack", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("wr_done", outs, O_IDLE);
    wr_in = 1'b0;

    // Spurious acks in IDLE and ACK
    ack_pulse();   chk("sp_idle0", outs, O_IDLE);
    tick();        chk("sp_idle1", outs, O_IDLE);
    req_in = 1'b1;
    tick(SYNC + 1); chk("sp_req", outs, O_RD);
    ack_pulse();   chk("sp_ack",  outs, O_ACK);
    ack_pulse();   chk("sp_ack0", outs, O_ACK);
    tick();        chk("sp_ack1", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("sp_idle2", outs, O_IDLE);
    req_in = 1'b1;
    tick(SYNC + 1); chk("sp_new",  outs, O_RD);
    tick();        chk("sp_nostore", outs, O_RD);
    ack_pulse();   chk("sp_newack", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("sp_end",  outs, O_IDLE);

`ifdef EJTAG_PRACC_TIMEOUT_EN
    // Timeout: DBG_REQ high exactly TOL cycles, error and ack together
    req_in = 1'b1;
    tick(SYNC + 1); chk("to_e0", outs, O_RD);
    for (int i = 1; i < TOL; i++) begin
      tick();      chk("to_hold", outs, O_RD);
    end
    tick();        chk("to_fire", outs, O_TOACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("to_sticky", outs, O_ERR);
    tick(3);       chk("to_sticky2", outs, O_ERR);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", outs, O_IDLE);

    // Timeout with ERR_CLR in the same cycle: set wins
    req_in = 1'b1;
    tick(SYNC + 1); chk("tc_e0", outs, O_RD);
    tick(TOL - 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tc_setwins", outs, O_TOACK);
    req_in = 1'b0;
    tick(SYNC + 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tc_clr", outs, O_IDLE);

    // Collision: DBG_ACK on the terminal count cycle
    req_in = 1'b1;
    tick(SYNC + 1); chk("col_e0", outs, O_RD);
    tick(TOL - 1);  chk("col_last", outs, O_RD);
    ack_pulse();    chk("col_ack", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("col_end", outs, O_IDLE);
`else
    // No timeout: REQ waits indefinitely, ERR_CLR has no effect
    req_in = 1'b1;
    tick(SYNC + 1); chk("nt_e0", outs, O_RD);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("nt_clr", outs, O_RD);
    tick(TOL + 10); chk("nt_wait", outs, O_RD);
    ack_pulse();    chk("nt_ack", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("nt_end", outs, O_IDLE);
`endif

    // Reset while in REQ with the request still held high
    req_in = 1'b1;
    tick(SYNC + 1); chk("rst_req", outs, O_RD);
    RESET = 1'b1;
    tick();        chk("rst_clr", outs, O_IDLE);
    RESET = 1'b0;
    tick();        chk("rst_r1", outs, O_IDLE);
    tick();        chk("rst_r2", outs, O_IDLE);
    tick();        chk("rst_r3", outs, O_RD);
    ack_pulse();   chk("rst_ack", outs, O_ACK);
    req_in = 1'b0;
    tick(SYNC + 1); chk("rst_end", outs, O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ejtag_pracc_hs_ctrl.md
Name: ejtag_pracc_hs_ctrl

Overview:
- Controls the EJTAG processor-access (PrAcc) handshake on the core side.
- Takes a 4-phase request level from the TCK domain and synchronises it into CLK, then sequences one debug bus access.
- Returns a 4-phase acknowledge level to the TCK domain, with a bounded wait for the core's acknowledge.
- Sits between the TAP-side PrAcc register and the core debug bus interface.

Parameters:
- SYNC_STAGES, 2: flop stages in each input synchroniser; legal values are 2 or 3.
- TO_WIDTH, 8: width of the timeout counter in bits.
- TO_LIMIT, 200: number of CLK cycles in REQ before a timeout; must satisfy 1 <= TO_LIMIT < 2**TO_WIDTH.

Ports:
- CLK  input  1  core clock; single clock domain.
- RESET  input  1  synchronous, active-high reset.
- PRACC_REQ_IN  input  1  async request level from TCK domain; 4-phase protocol.
- PRACC_WR_IN  input  1  async direction, 1 = write; stable before REQ rises and until ACK falls.
- DBG_ACK  input  1  one-cycle completion pulse from core debug bus.
- ERR_CLR  input  1  one-cycle pulse that clears TIMEOUT_ERR.
- DBG_REQ  output  1  debug bus request level, registered.
- DBG_WR  output  1  debug bus direction, registered; valid while DBG_REQ = 1.
- PRACC_ACK_OUT  output  1  acknowledge level back to TCK domain, registered.
- BUSY  output  1  high when the FSM is not in IDLE.
- TIMEOUT_ERR  output  1  sticky timeout flag.

Behaviour:
- Reset (RESET = 1 at a CLK edge):
  - All outputs go to 0, the FSM goes to IDLE, and all synchroniser flops and the counter clear.
  - Reset has priority over every other event.
- Synchronisers: req_s and wr_s are PRACC_REQ_IN and PRACC_WR_IN after SYNC_STAGES flops.
- FSM states: IDLE, REQ, ACK. Encoding constants are held in the package.
- IDLE:
  - If req_s = 1: go to REQ, set DBG_REQ = 1, set DBG_WR = wr_s, clear the counter.
- REQ:
  - DBG_REQ is held at 1 and the counter increments every cycle.
  - If DBG_ACK = 1: set DBG_REQ = 0 and PRACC_ACK_OUT = 1, go to ACK.
  - Else if counter = TO_LIMIT-1: set DBG_REQ = 0, PRACC_ACK_OUT = 1 and TIMEOUT_ERR = 1, go to ACK. The TCK side is never left hung.
  - DBG_ACK and the timeout in the same cycle: DBG_ACK wins and no error is flagged.
- ACK:
  - PRACC_ACK_OUT is held at 1.
  - When req_s = 0: set PRACC_ACK_OUT = 0, go to IDLE.
  - A new request is only possible after ACK falls, because IDLE is entered only when req_s = 0.
- DBG_ACK is ignored in IDLE and ACK; it is not counted and not stored.
- Latency:
  - REQ first sampled high at edge k gives DBG_REQ high after edge k+SYNC_STAGES.
  - DBG_ACK at edge m gives PRACC_ACK_OUT high after edge m.
  - REQ sampled low at edge n gives ACK low after edge n+SYNC_STAGES.
- TIMEOUT_ERR:
  - Set by a timeout; cleared by ERR_CLR.
  - Timeout and ERR_CLR in the same cycle: set wins.
- Counter: saturates rather than wraps; it can never wrap because it exits at TO_LIMIT-1.
- Reset mid-transaction:
  - Clears everything, and the pending DBG_REQ drops immediately.
  - If PRACC_REQ_IN is still high after reset, a fresh transaction starts; the TCK side re-issues.

Optional Feature:
- Macro EJTAG_PRACC_TIMEOUT_EN.
- Defined: timeout counter and TIMEOUT_ERR logic behave as described above; ERR_CLR is functional.
- Undefined:
  - No counter is present.
  - REQ waits indefinitely for DBG_ACK.
  - TIMEOUT_ERR is tied to 0 and ERR_CLR is ignored.
  - TO_WIDTH and TO_LIMIT are unused.

Decomposition:
- Shared package contents:
  - FSM state encoding constants (IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2).
  - Default TO_WIDTH and TO_LIMIT constants.
- One sub-module, ejtag_hs_sync:
  - Parameterised SYNC_STAGES-deep flop chain with synchronous active-high clear.
  - Instantiated twice, once for REQ and once for WR.

Test Plan:
- Read access: WR_IN = 0, REQ_IN = 1 at edge 10, DBG_ACK pulse 5 cycles after DBG_REQ rises, REQ_IN = 0 after ACK seen.
  - Required: DBG_REQ high after edge 12; DBG_WR = 0; PRACC_ACK_OUT high the edge after DBG_ACK; ACK low 2 edges after REQ low; BUSY matches the state.
- Write access: WR_IN = 1 set 3 cycles before REQ rises.
  - Required: DBG_WR = 1 for the whole time DBG_REQ is high.
- Timeout: TO_LIMIT = 4, no DBG_ACK.
  - Required: DBG_REQ high for exactly 4 cycles; TIMEOUT_ERR = 1 and PRACC_ACK_OUT = 1 on the same edge; TIMEOUT_ERR holds until an ERR_CLR pulse clears it.
- Collision: DBG_ACK arrives in the same cycle the counter reaches TO_LIMIT-1.
  - Required: TIMEOUT_ERR stays 0 and ACK is asserted.
- Spurious ack: DBG_ACK pulses in IDLE and in ACK.
  - Required: no state change; no DBG_REQ.
- Reset mid-operation: RESET asserted while in REQ, with REQ_IN held high.
  - Required: all outputs 0 the next edge; after RESET deasserts, DBG_REQ rises again SYNC_STAGES+1 edges later.
